// File: rtl/mmio_bridge_if.sv
// Signal bundle around mmio_bridge: core request port, memory controller port
// and COMM channel 1. The bridge uses the slave view, its environment the master view.
interface mmio_bridge_if;
    logic [1:0]  c_rw_flag;
    logic [31:0] c_addr;
    logic [31:0] c_write_data;
    logic [3:0]  c_write_mask;
    logic [31:0] c_read_data;
    logic        c_busy;
    logic        c_done;

    logic [1:0]  m_rw_flag;
    logic [31:0] m_addr;
    logic [31:0] m_write_data;
    logic [3:0]  m_write_mask;
    logic [31:0] m_read_data;
    logic        m_busy;
    logic        m_done;

    logic        io_write_flag;
    logic [71:0] io_write_data;
    logic [4:0]  io_write_length;
    logic        io_writable;
    logic        io_read_flag;
    logic [71:0] io_read_data;
    logic [4:0]  io_read_length;
    logic        io_readable;
    logic [7:0]  io_drop_count;

    modport slave (
        input  c_rw_flag, c_addr, c_write_data, c_write_mask,
        output c_read_data, c_busy, c_done,
        output m_rw_flag, m_addr, m_write_data, m_write_mask,
        input  m_read_data, m_busy, m_done,
        output io_write_flag, io_write_data, io_write_length,
        input  io_writable,
        output io_read_flag,
        input  io_read_data, io_read_length, io_readable,
        output io_drop_count
    );

    modport master (
        output c_rw_flag, c_addr, c_write_data, c_write_mask,
        input  c_read_data, c_busy, c_done,
        input  m_rw_flag, m_addr, m_write_data, m_write_mask,
        output m_read_data, m_busy, m_done,
        input  io_write_flag, io_write_data, io_write_length,
        output io_writable,
        input  io_read_flag,
        output io_read_data, io_read_length, io_readable,
        input  io_drop_count
    );
endinterface

// File: rtl/mmio_bridge.sv
// Data-port address decoder: addr[31]==0 goes to the memory controller,
// addr[31]==1 becomes an MMIO message exchange on COMM channel 1.
module mmio_bridge #(
    parameter logic [7:0] IO_OPCODE_W = 8'h57,
    parameter logic [7:0] IO_OPCODE_R = 8'h52
) (
    input  logic         CLK,
    input  logic         RST,
    mmio_bridge_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_IO_SEND,
        ST_IO_WAIT,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic        r_is_write;
    logic [31:0] r_rdata;
    logic [7:0]  r_drop_cnt;

    logic        w_req_valid;
    logic        w_latch_req;
    logic        w_rdata_load;
    logic [31:0] w_rdata_in;
    logic        w_drop_inc;

    logic [1:0]  w_m_rw_flag;
    logic [31:0] w_m_addr;
    logic [31:0] w_m_wdata;
    logic [3:0]  w_m_mask;
    logic        w_io_wflag;
    logic [71:0] w_io_wdata;
    logic [4:0]  w_io_wlen;
    logic        w_io_rflag;
    logic        w_c_done;

    logic [7:0]  w_msg_bytes [0:8];
    logic [71:0] w_msg;

    // Bits the bridge deliberately ignores: controller busy, MMIO address
    // bits [30:16] and reply bytes beyond the 4-byte read result.
    logic        w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.m_busy, bus.c_addr[30:16], bus.io_read_data[71:32]};

    assign w_req_valid = (bus.c_rw_flag == 2'b01) || (bus.c_rw_flag == 2'b10);

    // Outgoing message as a byte list; unused trailing bytes stay zero.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_msg_bytes[k] = 8'h00;
        end
        w_msg_bytes[1] = r_addr[7:0];
        w_msg_bytes[2] = r_addr[15:8];
        if (r_is_write) begin
            w_msg_bytes[0] = IO_OPCODE_W;
            w_msg_bytes[3] = {4'h0, r_mask};
            w_msg_bytes[4] = r_wdata[7:0];
            w_msg_bytes[5] = r_wdata[15:8];
            w_msg_bytes[6] = r_wdata[23:16];
            w_msg_bytes[7] = r_wdata[31:24];
        end else begin
            w_msg_bytes[0] = IO_OPCODE_R;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_msg_pack
            assign w_msg[gi*8 +: 8] = w_msg_bytes[gi];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_latch_req  = 1'b0;
        w_rdata_load = 1'b0;
        w_rdata_in   = r_rdata;
        w_drop_inc   = 1'b0;
        w_m_rw_flag  = 2'b00;
        w_m_addr     = 32'h0;
        w_m_wdata    = 32'h0;
        w_m_mask     = 4'h0;
        w_io_wflag   = 1'b0;
        w_io_wdata   = 72'h0;
        w_io_wlen    = 5'd0;
        w_io_rflag   = 1'b0;
        w_c_done     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_req_valid) begin
                    w_latch_req  = 1'b1;
                    w_state_next = bus.c_addr[31] ? ST_IO_SEND : ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                w_m_rw_flag = r_is_write ? 2'b10 : 2'b01;
                w_m_addr    = r_addr;
                w_m_wdata   = r_wdata;
                w_m_mask    = r_mask;
                if (bus.m_done) begin
                    w_rdata_load = !r_is_write;
                    w_rdata_in   = bus.m_read_data;
                    w_state_next = ST_DONE;
                end
            end
            ST_IO_SEND: begin
                w_io_wdata = w_msg;
                w_io_wlen  = r_is_write ? 5'd8 : 5'd3;
                if (bus.io_writable) begin
                    w_io_wflag   = 1'b1;
                    w_state_next = r_is_write ? ST_DONE : ST_IO_WAIT;
                end
            end
            ST_IO_WAIT: begin
                // Every presented reply is consumed; only a 4-byte one completes the read.
                if (bus.io_readable) begin
                    w_io_rflag = 1'b1;
                    if (bus.io_read_length == 5'd4) begin
                        w_rdata_load = 1'b1;
                        w_rdata_in   = bus.io_read_data[31:0];
                        w_state_next = ST_DONE;
                    end else begin
                        w_drop_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_c_done     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_mask     <= 4'h0;
            r_is_write <= 1'b0;
            r_rdata    <= 32'h0;
            r_drop_cnt <= 8'h0;
        end else begin
            r_state <= w_state_next;
            if (w_latch_req) begin
                r_addr     <= bus.c_addr;
                r_wdata    <= bus.c_write_data;
                r_mask     <= bus.c_write_mask;
                r_is_write <= (bus.c_rw_flag == 2'b10);
            end
            if (w_rdata_load) begin
                r_rdata <= w_rdata_in;
            end
            if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign bus.c_read_data     = r_rdata;
    assign bus.c_busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.c_done          = w_c_done;
    assign bus.m_rw_flag       = w_m_rw_flag;
    assign bus.m_addr          = w_m_addr;
    assign bus.m_write_data    = w_m_wdata;
    assign bus.m_write_mask    = w_m_mask;
    assign bus.io_write_flag   = w_io_wflag;
    assign bus.io_write_data   = w_io_wdata;
    assign bus.io_write_length = w_io_wlen;
    assign bus.io_read_flag    = w_io_rflag;
    assign bus.io_drop_count   = r_drop_cnt;
endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios plus randomized
// traffic against a transaction-level model of the bridge.
module tb_mmio_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_bridge_if bus();

    mmio_bridge #(
        .IO_OPCODE_W (8'h57),
        .IO_OPCODE_R (8'h52)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: last completed read result and saturating drop count.
    logic [31:0] mdl_rdata;
    int          mdl_drops;

    // Expected channel message built byte-by-byte from the message format.
    function automatic logic [71:0] exp_msg(input logic wr, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] m);
        logic [7:0]  b [0:7];
        logic [71:0] v;
        int          n;
        v = '0;
        for (int k = 0; k < 8; k++) b[k] = 8'h00;
        b[0] = wr ? 8'h57 : 8'h52;
        b[1] = a[7:0];
        b[2] = a[15:8];
        n    = 3;
        if (wr) begin
            b[3] = {4'h0, m};
            b[4] = d[7:0];
            b[5] = d[15:8];
            b[6] = d[23:16];
            b[7] = d[31:24];
            n    = 8;
        end
        for (int k = 0; k < n; k++) v[8*k +: 8] = b[k];
        return v;
    endfunction

    task automatic idle_inputs();
        bus.c_rw_flag    = 2'b00;
        bus.c_addr       = 32'h0;
        bus.c_write_data = 32'h0;
        bus.c_write_mask = 4'h0;
        bus.m_read_data  = 32'h0;
        bus.m_busy       = 1'b0;
        bus.m_done       = 1'b0;
        bus.io_writable  = 1'b0;
        bus.io_read_data = 72'h0;
        bus.io_read_length = 5'd0;
        bus.io_readable  = 1'b0;
    endtask

    task automatic mem_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input int lat, input logic [31:0] rd);
        @(posedge clk); #1;
        bus.c_rw_flag    = wr ? 2'b10 : 2'b01;
        bus.c_addr       = a;
        bus.c_write_data = d;
        bus.c_write_mask = m;
        @(negedge clk);
        n_tests++;
        if (bus.c_busy !== 1'b0 || bus.c_done !== 1'b0) begin
            n_fail++; $display("FAIL mem_req_cycle0: busy/done got %b%b, expected 00", bus.c_busy, bus.c_done);
        end
        @(posedge clk); #1;
        bus.c_rw_flag    = 2'b00;
        bus.c_addr       = $urandom;
        bus.c_write_data = $urandom;
        for (int c = 1; c <= lat; c++) begin
            bus.m_busy = 1'($urandom);
            if (c == lat) begin
                bus.m_done      = 1'b1;
                bus.m_read_data = rd;
            end else begin
                bus.m_read_data = $urandom;
            end
            @(negedge clk);
            n_tests++;
            if ({bus.m_rw_flag, bus.m_addr, bus.m_write_data, bus.m_write_mask} !== {(wr ? 2'b10 : 2'b01), a, d, m}) begin
                n_fail++; $display("FAIL mem_fields: got %h, expected %h",
                    {bus.m_rw_flag, bus.m_addr, bus.m_write_data, bus.m_write_mask}, {(wr ? 2'b10 : 2'b01), a, d, m});
            end
            n_tests++;
            if ({bus.c_busy, bus.c_done, bus.io_write_flag, bus.io_read_flag} !== 4'b1000) begin
                n_fail++; $display("FAIL mem_busy: busy/done/wflag/rflag got %b, expected 1000",
                    {bus.c_busy, bus.c_done, bus.io_write_flag, bus.io_read_flag});
            end
            @(posedge clk); #1;
        end
        bus.m_done = 1'b0;
        bus.m_busy = 1'b0;
        if (!wr) mdl_rdata = rd;
        @(negedge clk);
        n_tests++;
        if ({bus.c_done, bus.c_busy, bus.m_rw_flag} !== 4'b1000) begin
            n_fail++; $display("FAIL mem_done: done/busy/m_rw got %b, expected 1000", {bus.c_done, bus.c_busy, bus.m_rw_flag});
        end
        n_tests++;
        if (bus.c_read_data !== mdl_rdata) begin
            n_fail++; $display("FAIL mem_rdata: got %h, expected %h", bus.c_read_data, mdl_rdata);
        end
    endtask

    task automatic io_write_txn(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] m, input int stall);
        logic [71:0] exp;
        int          pulses;
        exp    = exp_msg(1'b1, a, d, m);
        pulses = 0;
        @(posedge clk); #1;
        bus.c_rw_flag    = 2'b10;
        bus.c_addr       = a;
        bus.c_write_data = d;
        bus.c_write_mask = m;
        @(negedge clk);
        n_tests++;
        if (bus.c_busy !== 1'b0 || bus.io_write_flag !== 1'b0) begin
            n_fail++; $display("FAIL iow_cycle0: busy/wflag got %b%b, expected 00", bus.c_busy, bus.io_write_flag);
        end
        @(posedge clk); #1;
        bus.c_rw_flag = 2'b00;
        bus.c_addr    = $urandom;
        for (int c = 1; c <= stall + 1; c++) begin
            bus.io_writable = (c == stall + 1);
            @(negedge clk);
            if (bus.io_write_flag === 1'b1) pulses++;
            n_tests++;
            if (bus.io_write_flag !== (c == stall + 1)) begin
                n_fail++; $display("FAIL iow_flag: cycle %0d got %b, expected %b", c, bus.io_write_flag, (c == stall + 1));
            end
            n_tests++;
            if ({bus.io_write_length, bus.io_write_data} !== {5'd8, exp}) begin
                n_fail++; $display("FAIL iow_msg: got len %0d data %h, expected len 8 data %h",
                    bus.io_write_length, bus.io_write_data, exp);
            end
            n_tests++;
            if ({bus.c_busy, bus.m_rw_flag, bus.io_read_flag} !== 4'b1000) begin
                n_fail++; $display("FAIL iow_busy: busy/m_rw/rflag got %b, expected 1000", {bus.c_busy, bus.m_rw_flag, bus.io_read_flag});
            end
            @(posedge clk); #1;
        end
        bus.io_writable = 1'($urandom);
        @(negedge clk);
        n_tests++;
        if ({bus.c_done, bus.c_busy, bus.io_write_flag, bus.m_rw_flag} !== 5'b10000) begin
            n_fail++; $display("FAIL iow_done: done/busy/wflag/m_rw got %b, expected 10000",
                {bus.c_done, bus.c_busy, bus.io_write_flag, bus.m_rw_flag});
        end
        n_tests++;
        if (pulses != 1 || bus.c_read_data !== mdl_rdata) begin
            n_fail++; $display("FAIL iow_pulses: pulses %0d rdata %h, expected 1 and %h", pulses, bus.c_read_data, mdl_rdata);
        end
    endtask

    task automatic io_read_txn(input logic [31:0] a, input int delay, input int nbad,
                               input int bad_len, input logic [31:0] gd);
        logic [71:0] exp;
        int          l;
        exp = exp_msg(1'b0, a, 32'h0, 4'h0);
        @(posedge clk); #1;
        bus.c_rw_flag    = 2'b01;
        bus.c_addr       = a;
        bus.c_write_data = $urandom;
        bus.c_write_mask = 4'($urandom);
        @(negedge clk);
        n_tests++;
        if (bus.c_busy !== 1'b0 || bus.c_done !== 1'b0) begin
            n_fail++; $display("FAIL ior_cycle0: busy/done got %b%b, expected 00", bus.c_busy, bus.c_done);
        end
        @(posedge clk); #1;
        bus.c_rw_flag   = 2'b00;
        bus.io_writable = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.io_write_flag, bus.io_write_length, bus.io_write_data} !== {1'b1, 5'd3, exp}) begin
            n_fail++; $display("FAIL ior_msg: got flag %b len %0d data %h, expected 1 3 %h",
                bus.io_write_flag, bus.io_write_length, bus.io_write_data, exp);
        end
        for (int c = 0; c < delay; c++) begin
            @(posedge clk); #1;
            bus.io_writable    = 1'($urandom);
            bus.io_read_length = 5'd4;
            bus.io_read_data   = {8'($urandom), $urandom, $urandom};
            @(negedge clk);
            n_tests++;
            if ({bus.io_read_flag, bus.io_write_flag, bus.c_busy, bus.c_done} !== 4'b0010) begin
                n_fail++; $display("FAIL ior_wait: rflag/wflag/busy/done got %b, expected 0010",
                    {bus.io_read_flag, bus.io_write_flag, bus.c_busy, bus.c_done});
            end
        end
        for (int b = 0; b <= nbad; b++) begin
            @(posedge clk); #1;
            if (b < nbad) begin
                if (bad_len >= 0) l = bad_len;
                else begin
                    l = int'($urandom_range(0, 31));
                    if (l == 4) l = 9;
                end
            end else begin
                l = 4;
            end
            bus.io_readable    = 1'b1;
            bus.io_writable    = 1'($urandom);
            bus.io_read_length = 5'(l);
            bus.io_read_data   = {8'($urandom), $urandom, ((b < nbad) ? $urandom : gd)};
            @(negedge clk);
            n_tests++;
            if ({bus.io_read_flag, bus.io_write_flag} !== 2'b10) begin
                n_fail++; $display("FAIL ior_pop: rflag/wflag got %b, expected 10", {bus.io_read_flag, bus.io_write_flag});
            end
            @(posedge clk); #1;
            bus.io_readable = 1'b0;
            if (b < nbad) begin
                if (mdl_drops < 255) mdl_drops++;
            end else begin
                mdl_rdata = gd;
            end
            @(negedge clk);
            n_tests++;
            if ({bus.c_done, bus.c_busy, bus.io_read_flag} !== {(b == nbad), (b < nbad), 1'b0}) begin
                n_fail++; $display("FAIL ior_after: done/busy/rflag got %b, expected %b",
                    {bus.c_done, bus.c_busy, bus.io_read_flag}, {(b == nbad), (b < nbad), 1'b0});
            end
            n_tests++;
            if (bus.io_drop_count !== 8'(mdl_drops)) begin
                n_fail++; $display("FAIL ior_drops: got %0d, expected %0d", bus.io_drop_count, mdl_drops);
            end
            if (b == nbad) begin
                n_tests++;
                if (bus.c_read_data !== mdl_rdata) begin
                    n_fail++; $display("FAIL ior_rdata: got %h, expected %h", bus.c_read_data, mdl_rdata);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_tests++;
        if ({bus.c_read_data, bus.c_busy, bus.c_done, bus.m_rw_flag, bus.m_addr, bus.m_write_data,
             bus.m_write_mask, bus.io_write_flag, bus.io_write_data, bus.io_write_length,
             bus.io_read_flag, bus.io_drop_count} !== '0) begin
            n_fail++; $display("FAIL %s: outputs not all zero, rdata %h busy %b done %b m_rw %b wflag %b wlen %0d rflag %b drops %0d",
                tag, bus.c_read_data, bus.c_busy, bus.c_done, bus.m_rw_flag, bus.io_write_flag,
                bus.io_write_length, bus.io_read_flag, bus.io_drop_count);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mdl_rdata = 32'h0;
        mdl_drops = 0;
        @(negedge clk);
        check_all_zero("reset_values");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_mem_read();
        mem_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3, 32'hDEAD_BEEF);
    endtask

    task automatic test_io_write();
        io_write_txn(32'h8000_1234, 32'h1122_3344, 4'b0110, 0);
    endtask

    task automatic test_io_read();
        io_read_txn(32'h8000_00A0, 9, 0, -1, 32'hDEAD_BEEF);
    endtask

    task automatic test_bad_reply();
        io_read_txn(32'h8000_0040, 2, 1, 2, 32'hCAFE_F00D);
    endtask

    task automatic test_write_stall();
        io_write_txn(32'hFFFF_ABCC, 32'hA5A5_0F0F, 4'b1111, 5);
    endtask

    task automatic test_idle_code11();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.c_rw_flag   = 2'b11;
            bus.c_addr      = $urandom;
            bus.io_writable = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({bus.c_busy, bus.c_done, bus.m_rw_flag, bus.io_write_flag} !== 5'b00000) begin
                n_fail++; $display("FAIL code11_idle: busy/done/m_rw/wflag got %b, expected 00000",
                    {bus.c_busy, bus.c_done, bus.m_rw_flag, bus.io_write_flag});
            end
        end
        @(posedge clk); #1;
        bus.c_rw_flag = 2'b00;
        @(negedge clk);
        n_tests++;
        if (bus.c_busy !== 1'b0) begin
            n_fail++; $display("FAIL code11_after: busy got %b, expected 0", bus.c_busy);
        end
    endtask

    // Back-to-back random mix: each transaction starts the cycle after the previous c_done.
    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        int          kind;
        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 3));
            d    = $urandom;
            a    = $urandom & 32'hFFFF_FFFC;
            case (kind)
                0: mem_txn(1'b0, a & 32'h7FFF_FFFF, d, 4'($urandom), int'($urandom_range(1, 5)), $urandom);
                1: mem_txn(1'b1, a & 32'h7FFF_FFFF, d, 4'($urandom), int'($urandom_range(1, 5)), $urandom);
                2: io_write_txn(a | 32'h8000_0000, d, 4'($urandom), int'($urandom_range(0, 3)));
                default: io_read_txn(a | 32'h8000_0000, int'($urandom_range(0, 4)),
                                     int'($urandom_range(0, 2)), -1, d);
            endcase
        end
    endtask

    task automatic test_drop_saturation();
        io_read_txn(32'h8000_0200, 0, 258, -1, 32'h0BAD_CAFE);
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        bus.c_rw_flag = 2'b01;
        bus.c_addr    = 32'h8000_0300;
        @(posedge clk); #1;
        bus.c_rw_flag   = 2'b00;
        bus.io_writable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.io_writable = 1'b0;
        mdl_rdata = 32'h0;
        mdl_drops = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("reset_mid_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        mem_txn(1'b0, 32'h0000_0ABC, 32'h0, 4'h0, 2, 32'h1357_9BDF);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.io_readable    = 1'b1;
            bus.io_read_length = 5'd4;
            bus.io_read_data   = {8'h00, 32'h0, $urandom};
            @(negedge clk);
            n_tests++;
            if ({bus.io_read_flag, bus.c_busy, bus.c_done} !== 3'b000) begin
                n_fail++; $display("FAIL late_reply: rflag/busy/done got %b, expected 000",
                    {bus.io_read_flag, bus.c_busy, bus.c_done});
            end
        end
        @(posedge clk); #1;
        bus.io_readable = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.c_read_data !== mdl_rdata) begin
            n_fail++; $display("FAIL late_reply_rdata: got %h, expected %h", bus.c_read_data, mdl_rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_mem_read();
        test_io_write();
        test_io_read();
        test_bad_reply();
        test_write_stall();
        test_idle_code11();
        test_back_to_back();
        test_drop_saturation();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Address decoder and protocol bridge on the core's data memory port. Requests with `addr[31]==0` pass through to the memory controller. Requests with `addr[31]==1` become MMIO transactions, encoded as messages on COMM channel 1, which is otherwise unused. The block lets the core reach host-side I/O over the shared UART link without changing the memory controller.

## Interface
Parameters:
- `IO_OPCODE_W`, 8'h57: opcode byte for MMIO write messages.
- `IO_OPCODE_R`, 8'h52: opcode byte for MMIO read messages.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: clock.
- `RST` in 1: synchronous active-high reset.
- `c_rw_flag` in 2: core request; 00 idle, 01 read, 10 write, 11 treated as idle.
- `c_addr` in 32: core address, word aligned.
- `c_write_data` in 32: core write data.
- `c_write_mask` in 4: byte enables; bit k covers `data[8k+7:8k]`.
- `c_read_data` out 32: read result, valid on `c_done`.
- `c_busy` out 1: high while a request is in flight.
- `c_done` out 1: one-cycle completion pulse.
- `m_rw_flag` out 2: request to the memory controller.
- `m_addr` out 32, `m_write_data` out 32, `m_write_mask` out 4: forwarded request fields.
- `m_read_data` in 32, `m_busy` in 1, `m_done` in 1: memory controller response.
- `io_write_flag` out 1: one-cycle pulse that pushes a message to channel 1.
- `io_write_data` out 72, `io_write_length` out 5: outgoing message; byte k sits at `[8k+7:8k]`; length is in bytes.
- `io_writable` in 1: channel 1 can accept a message.
- `io_read_flag` out 1: one-cycle pulse that pops the presented message.
- `io_read_data` in 72, `io_read_length` in 5, `io_readable` in 1: incoming message, valid while `io_readable` is high.
- `io_drop_count` out 8: saturating count of malformed replies.

## Operation
- States: IDLE, MEM_REQ, IO_SEND, IO_WAIT, DONE.
- IDLE: on `c_rw_flag` of 01 or 10, latch addr, data, mask and op.
  - `addr[31]==0` -> MEM_REQ.
  - `addr[31]==1` -> IO_SEND.
- MEM_REQ:
  - Drive `m_rw_flag` and the `m_*` fields from the latched copies; hold them until `m_done`.
  - On `m_done`, latch `m_read_data` (reads only) and go to DONE.
  - `m_busy` is informational only.
- IO_SEND, write op:
  - Message is 8 bytes: {`IO_OPCODE_W`, addr[7:0], addr[15:8], mask, data[7:0], data[15:8], data[23:16], data[31:24]}, with `io_write_length`=8.
  - Wait for `io_writable`, pulse `io_write_flag`, then go to DONE.
  - Writes get no acknowledgement.
- IO_SEND, read op:
  - Message is 3 bytes: {`IO_OPCODE_R`, addr[7:0], addr[15:8]}, with `io_write_length`=3.
  - After the pulse -> IO_WAIT.
- IO_WAIT, on `io_readable`:
  - Always pulse `io_read_flag` to consume the message.
  - Length 4: `c_read_data`={byte3,byte2,byte1,byte0}, then go to DONE.
  - Any other length: discard, increment `io_drop_count` (saturating at 255), stay in IO_WAIT.
- DONE: `c_done`=1 for exactly one cycle, then IDLE.
- `c_busy` = (state != IDLE && state != DONE).
- Address bits [30:16] are ignored for MMIO.
- The core must drop or change `c_rw_flag` in the cycle after `c_done`. A request still held in IDLE is treated as a new request.
- `io_write_data` bytes above `io_write_length` are zero.

## Timing
- Reset values: all outputs 0; state IDLE; `io_drop_count` 0. Applies at any point, including mid-transaction. In-flight transactions are abandoned and no `c_done` is issued.
- A memory pass-through adds 2 cycles:
  - Request is sampled at cycle 0.
  - `m_rw_flag` is valid from cycle 1.
  - `m_done` arrives at cycle N.
  - `c_done` pulses at cycle N+1.
- MMIO write with `io_writable` already high: request at cycle 0, `io_write_flag` at cycle 1, `c_done` at cycle 2.
- MMIO read: `io_read_flag` is asserted in the first IO_WAIT cycle with `io_readable`=1, and `c_done` pulses the next cycle.
- No timeout: IO_WAIT holds indefinitely until reset.
- `io_write_flag` and `io_read_flag` are never asserted while the respective `io_writable` or `io_readable` is low.
- Both flags are never high in the same cycle.

## Test plan
- Read of 0x00000100; memory returns 0xDEADBEEF with `m_done` 3 cycles after the request -> `m_addr`=0x00000100; `c_done` one cycle later with `c_read_data`=0xDEADBEEF; `c_busy` high throughout.
- Write to 0x80001234, data 0x11223344, mask 4'b0110, `io_writable`=1 -> `io_write_length`=8, `io_write_data`=72'h11223344_06_12_34_57 in byte order {57,34,12,06,44,33,22,11}; `c_done` at cycle 2; `m_rw_flag` stays 00.
- Read of 0x800000A0, with a 4-byte reply {EF,BE,AD,DE} arriving 10 cycles later -> outgoing message {52,A0,00} of length 3; `io_read_flag` pulses once; `c_read_data`=0xDEADBEEF.
- MMIO read receives a 2-byte reply, then a 4-byte reply -> first is popped and `io_drop_count`=1 with no `c_done`; second completes normally.
- `io_writable` low for 5 cycles during an MMIO write -> no `io_write_flag` until it rises; exactly one pulse after.
- `RST` asserted while in IO_WAIT, then a memory read is issued -> all outputs 0 after reset; the new read completes normally, and a late channel-1 reply arriving in IDLE is not consumed.
